// File: rtl/sf_ctrl.sv
// HN-F snoop-filter port sequencer: arbitrates SLC ReadUnique lookups against POCQ ownership
// updates, invalidates a displaced owner with SnpUnique, then records the requester as unique owner.

module sf_ctrl_chk #(
    parameter int unsigned ADDR_W = 48,
    parameter int unsigned ID_W   = 7
) (
    input logic              clock,
    input logic              reset,
    input logic              in_idle,
    input logic              lk_ready,
    input logic              up_ready,
    input logic              sf_rd_valid,
    input logic              sf_wr_valid,
    input logic [ADDR_W-1:0] sf_addr,
    input logic              snp_valid,
    input logic              snp_ready,
    input logic [ID_W-1:0]   snp_tgt,
    input logic [ADDR_W-1:0] snp_addr
);
    a_strobe_excl: assert property (@(posedge clock) disable iff (reset)
        !(sf_rd_valid && sf_wr_valid));

    a_ready_excl: assert property (@(posedge clock) disable iff (reset)
        !(lk_ready && up_ready));

    a_ready_idle: assert property (@(posedge clock) disable iff (reset)
        (lk_ready || up_ready) |-> in_idle);

    a_addr_quiet: assert property (@(posedge clock) disable iff (reset)
        !(sf_rd_valid || sf_wr_valid) |-> (sf_addr == {ADDR_W{1'b0}}));

    a_snp_hold: assert property (@(posedge clock) disable iff (reset)
        (snp_valid && !snp_ready) |=> (snp_valid && $stable(snp_tgt) && $stable(snp_addr)));
endmodule

module sf_ctrl #(
    parameter int unsigned        ADDR_W   = 48,
    parameter int unsigned        ID_W     = 7,
    parameter int unsigned        STATE_W  = 3,
    parameter logic [STATE_W-1:0] UC_STATE = 3'd2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               lk_valid,
    output logic               lk_ready,
    input  logic [ADDR_W-1:0]  lk_addr,
    input  logic [ID_W-1:0]    lk_srcid,
    input  logic               up_valid,
    output logic               up_ready,
    input  logic [ADDR_W-1:0]  up_addr,
    input  logic [ID_W-1:0]    up_srcid,
    input  logic [STATE_W-1:0] up_state,
    output logic               sf_rd_valid,
    output logic [ADDR_W-1:0]  sf_addr,
    input  logic               sf_hit,
    input  logic [ID_W-1:0]    sf_hit_owner,
    output logic               sf_wr_valid,
    output logic [ID_W-1:0]    sf_wr_owner,
    output logic [STATE_W-1:0] sf_wr_state,
    output logic               snp_valid,
    input  logic               snp_ready,
    output logic [ID_W-1:0]    snp_tgt,
    output logic [ADDR_W-1:0]  snp_addr,
    input  logic               snp_rsp_valid,
    output logic               lk_done,
    output logic               lk_snooped
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UPD      = 3'd1,
        ST_LOOKUP   = 3'd2,
        ST_SNOOP    = 3'd3,
        ST_SNP_WAIT = 3'd4,
        ST_WRITE    = 3'd5,
        ST_DONE     = 3'd6
    } sf_state_e;

    sf_state_e          state_r;
    sf_state_e          state_s;
    sf_state_e          out_state_s;
    logic               rr_last_r;     // 1: the lookup side won the most recent grant
    logic [ADDR_W-1:0]  cap_addr_r;
    logic [ID_W-1:0]    cap_srcid_r;
    logic [ID_W-1:0]    cap_owner_r;
    logic [STATE_W-1:0] cap_state_r;
    logic               snooped_r;
    logic               rsp_seen_r;
    logic               grant_lk_s;
    logic               grant_up_s;
    logic               need_snoop_s;

    // Round-robin grant, only offered from IDLE and never while reset is held
    always_comb begin
        grant_lk_s = 1'b0;
        grant_up_s = 1'b0;
        if (!reset && (state_r == ST_IDLE)) begin
            if (lk_valid && up_valid) begin
                grant_lk_s = ~rr_last_r;
                grant_up_s = rr_last_r;
            end else begin
                grant_lk_s = lk_valid;
                grant_up_s = up_valid;
            end
        end else begin
            grant_lk_s = 1'b0;
            grant_up_s = 1'b0;
        end
    end

    // A hit owned by a different RN-F must be invalidated before ownership moves
    always_comb begin
        need_snoop_s = 1'b0;
        if (state_r == ST_LOOKUP) begin
            need_snoop_s = sf_hit && (sf_hit_owner != cap_srcid_r);
        end else begin
            need_snoop_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_lk_s) begin
                    state_s = ST_LOOKUP;
                end else if (grant_up_s) begin
                    state_s = ST_UPD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_UPD:    state_s = ST_IDLE;
            ST_LOOKUP: begin
                if (need_snoop_s) begin
                    state_s = ST_SNOOP;
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_SNOOP: begin
                if (snp_ready) begin
                    state_s = ST_SNP_WAIT;
                end else begin
                    state_s = ST_SNOOP;
                end
            end
            ST_SNP_WAIT: begin
                if (snp_rsp_valid || rsp_seen_r) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_SNP_WAIT;
                end
            end
            ST_WRITE: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Request capture, snoop bookkeeping and round-robin history
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_r   <= 1'b0;
            cap_addr_r  <= {ADDR_W{1'b0}};
            cap_srcid_r <= {ID_W{1'b0}};
            cap_owner_r <= {ID_W{1'b0}};
            cap_state_r <= {STATE_W{1'b0}};
            snooped_r   <= 1'b0;
            rsp_seen_r  <= 1'b0;
        end else begin
            if (grant_lk_s) begin
                rr_last_r   <= 1'b1;
                cap_addr_r  <= lk_addr;
                cap_srcid_r <= lk_srcid;
                cap_state_r <= {STATE_W{1'b0}};
                snooped_r   <= 1'b0;
                rsp_seen_r  <= 1'b0;
            end else if (grant_up_s) begin
                rr_last_r   <= 1'b0;
                cap_addr_r  <= up_addr;
                cap_srcid_r <= up_srcid;
                cap_state_r <= up_state;
            end
            if (need_snoop_s) begin
                cap_owner_r <= sf_hit_owner;
                snooped_r   <= 1'b1;
            end
            // A response racing the snoop handshake is remembered for SNP_WAIT
            if ((state_r == ST_SNOOP) && snp_ready && snp_rsp_valid) begin
                rsp_seen_r <= 1'b1;
            end
        end
    end

    // Output decode; reset forces the quiet IDLE decode so nothing leaks mid-abort
    always_comb begin
        out_state_s = reset ? ST_IDLE : state_r;
        lk_ready    = grant_lk_s;
        up_ready    = grant_up_s;
        sf_rd_valid = 1'b0;
        sf_wr_valid = 1'b0;
        sf_addr     = {ADDR_W{1'b0}};
        sf_wr_owner = {ID_W{1'b0}};
        sf_wr_state = {STATE_W{1'b0}};
        snp_valid   = 1'b0;
        snp_tgt     = {ID_W{1'b0}};
        snp_addr    = {ADDR_W{1'b0}};
        lk_done     = 1'b0;
        lk_snooped  = 1'b0;
        case (out_state_s)
            ST_UPD: begin
                sf_wr_valid = 1'b1;
                sf_addr     = cap_addr_r;
                sf_wr_owner = cap_srcid_r;
                sf_wr_state = cap_state_r;
            end
            ST_LOOKUP: begin
                sf_rd_valid = 1'b1;
                sf_addr     = cap_addr_r;
            end
            ST_SNOOP: begin
                snp_valid = 1'b1;
                snp_tgt   = cap_owner_r;
                snp_addr  = cap_addr_r;
            end
            ST_WRITE: begin
                sf_wr_valid = 1'b1;
                sf_addr     = cap_addr_r;
                sf_wr_owner = cap_srcid_r;
                sf_wr_state = UC_STATE;
            end
            ST_DONE: begin
                lk_done    = 1'b1;
                lk_snooped = snooped_r;
            end
            default: begin
                sf_rd_valid = 1'b0;
                sf_wr_valid = 1'b0;
            end
        endcase
    end

    sf_ctrl_chk #(
        .ADDR_W (ADDR_W),
        .ID_W   (ID_W)
    ) u_chk (
        .clock       (clock),
        .reset       (reset),
        .in_idle     (state_r == ST_IDLE),
        .lk_ready    (lk_ready),
        .up_ready    (up_ready),
        .sf_rd_valid (sf_rd_valid),
        .sf_wr_valid (sf_wr_valid),
        .sf_addr     (sf_addr),
        .snp_valid   (snp_valid),
        .snp_ready   (snp_ready),
        .snp_tgt     (snp_tgt),
        .snp_addr    (snp_addr)
    );

endmodule
